// File: rtl/multiply_add.sv
// multiply_add: sequential shift-add multiplier-accumulator, result = a*b + c, one multiplier bit per clock
module multiply_add #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mc;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   mp;
    logic [CW-1:0]      cnt;
    // accumulator value after this iteration's conditional add
    always_comb sum = mp[0] ? acc + mc : acc;
    // handshake FSM and shift-add datapath; last iteration commits sum straight to result
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                acc   <= {{WIDTH{1'b0}}, c};
                mc    <= {{WIDTH{1'b0}}, a};
                mp    <= b;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= RUN;
            end
        end else begin
            acc <= sum;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                result <= sum;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
            end
        end
    end
endmodule

// File: doc/multiply_add.md
Name: multiply_add

Overview:
- Sequential shift-add multiplier-accumulator: computes result = a*b + c, one multiplier bit per clock.
- Inverse of the restoring divider in the arithmetic unit. Feeding it quotient, divisor and remainder reconstructs the dividend.
- Sits alongside the divider in the mini processor datapath. Also serves as the multiply instruction when c = 0.
- start/busy/done handshake replaces the divider's edge-triggered enable.

Parameters:
- WIDTH, 8, operand width in bits. The result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand (e.g. quotient).
- b  input  WIDTH  multiplier (e.g. divisor).
- c  input  WIDTH  addend (e.g. remainder), zero-extended.
- result  output  2*WIDTH  a*b + c; valid from the done cycle onward.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: on any rising edge with rst=1:
  - state=IDLE, result=0, busy=0, done=0.
  - Internal accumulator, shifted multiplicand, multiplier shift register and counter all cleared.
  - rst has priority over start.
- States: IDLE, RUN.
- IDLE:
  - done is driven 0 unless the previous edge completed an operation.
  - On an edge with start=1, latch the operands:
    - acc <= zero-extended c.
    - mc <= zero-extended a (2*WIDTH bits).
    - mp <= b.
    - cnt <= 0.
  - On that same edge: busy <= 1, done <= 0, state <= RUN.
- RUN, each edge:
  - If mp[0]=1 then acc <= acc + mc.
  - mc <= mc << 1; mp <= mp >> 1; cnt <= cnt + 1.
  - On the edge where cnt = WIDTH-1 (the last iteration):
    - result <= final acc value, including this iteration's add.
    - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge k, so done=1 and result valid in the cycle after edge k+WIDTH. That is WIDTH cycles, fixed and independent of operand values.
- Widths and overflow:
  - All additions are 2*WIDTH bits wide.
  - The maximum value (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so overflow is impossible. No carry-out is kept.
- result holding: result changes only at completion or reset. It holds its value through IDLE and through the next operation until that operation completes.
- done is high for exactly one cycle per completed operation.
- start while busy=1 is ignored. Operand inputs are don't-care during RUN because all operands are latched.
- start high in the done cycle is accepted, since state is already IDLE:
  - done falls and busy rises on that edge.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- start held high continuously restarts immediately after each completion.
- rst during RUN aborts the operation:
  - No done pulse is produced.
  - result is cleared to 0.
- b=0 yields c. a=0 yields c. Both paths still take the full WIDTH cycles.

Test Plan:
- Basic: a=13, b=7, c=5, start pulsed -> busy high for 8 cycles, then done pulses once with result=0x0060 (96).
- Round trip: a=28, b=7, c=4 (the quotient and remainder of 200/7) -> result=0x00C8 (200).
- Maximum: a=0xFF, b=0xFF, c=0xFF -> result=0xFF00, with no wrap.
- Zero and ignored start:
  - a=0, b=200, c=9 -> result=9.
  - A second start with different operands pulsed mid-RUN is ignored: result is still 9, with exactly one done pulse.
- Back-to-back: start held high across two operations (3*4+1, then 10*10+0) -> done pulses at 8 and 17 cycles after the first start edge; result shows 13, then 100; busy is low only in the done cycles.
- Reset mid-operation: rst asserted at cycle 4 of RUN -> the next cycle shows busy=0, done=0, result=0, and no done pulse follows. A new start then completes normally.
